// File: rtl/memory_arbiter.sv
// Round-robin arbiter that gives the instruction and data caches shared access to one line-wide memory port.
// Each transaction runs IDLE -> BUSY -> DONE, and a stalled memory is cut off by a timeout.
module memory_arbiter #(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ic_req,
  input  logic [ADDRESS_SIZE-1:0]    ic_address,
  output logic [CACHE_LINE_SIZE-1:0] ic_data_out,
  output logic                       ic_ready,
  input  logic                       dc_req,
  input  logic                       dc_op,
  input  logic [ADDRESS_SIZE-1:0]    dc_address,
  input  logic [CACHE_LINE_SIZE-1:0] dc_data_in,
  output logic [CACHE_LINE_SIZE-1:0] dc_data_out,
  output logic                       dc_ready,
  output logic                       mem_enable,
  output logic                       mem_op,
  output logic [ADDRESS_SIZE-1:0]    mem_address,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
  output logic                       mem_op_done,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
  input  logic                       mem_data_ready,
  output logic                       busy,
  output logic                       error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic             grant_dc;
  logic             last_dc;
  logic             take_dc;
  logic [CNT_W-1:0] timeout_cnt;

  // On a tie, the requester that was not served last goes next.
  function automatic logic pick_dc(input logic ic, input logic dc, input logic last_was_dc);
    if (ic && dc) return !last_was_dc;
    return dc;
  endfunction

  always_comb begin
    take_dc = pick_dc(ic_req, dc_req, last_dc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_dc    <= 1'b0;
      last_dc     <= 1'b0;
      timeout_cnt <= '0;
      mem_enable  <= 1'b0;
      mem_op      <= 1'b0;
      mem_op_done <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      ic_data_out <= '0;
      dc_data_out <= '0;
      ic_ready    <= 1'b0;
      dc_ready    <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_req || dc_req) begin
            grant_dc <= take_dc;
            if (take_dc) begin
              mem_address <= dc_address;
              mem_op      <= dc_op;
              mem_data_in <= dc_data_in;
            end else begin
              mem_address <= ic_address;
              mem_op      <= 1'b0;
              mem_data_in <= '0;
            end
            mem_enable  <= 1'b1;
            timeout_cnt <= '0;
            busy        <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          timeout_cnt <= timeout_cnt + CNT_W'(1);
          // Both a memory response and a timeout finish the transaction; only a response carries data.
          if (mem_data_ready || (timeout_cnt == CNT_LAST)) begin
            if (!mem_data_ready) error <= 1'b1;
            if (grant_dc) begin
              dc_ready <= 1'b1;
              if (mem_data_ready && !mem_op) dc_data_out <= mem_data_out;
            end else begin
              ic_ready <= 1'b1;
              if (mem_data_ready) ic_data_out <= mem_data_out;
            end
            mem_enable  <= 1'b0;
            mem_op_done <= 1'b1;
            last_dc     <= grant_dc;
            state       <= DONE;
          end
        end
        DONE: begin
          // Hold the acknowledge until memory has dropped its ready.
          if (!mem_data_ready) begin
            mem_op_done <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter. It covers reads, writes, arbitration order, timeout and reset abort.
module tb_memory_arbiter;

  logic         clk;
  logic         rst_n;
  logic         ic_req;
  logic [11:0]  ic_address;
  logic [127:0] ic_data_out;
  logic         ic_ready;
  logic         dc_req;
  logic         dc_op;
  logic [11:0]  dc_address;
  logic [127:0] dc_data_in;
  logic [127:0] dc_data_out;
  logic         dc_ready;
  logic         mem_enable;
  logic         mem_op;
  logic [11:0]  mem_address;
  logic [127:0] mem_data_in;
  logic         mem_op_done;
  logic [127:0] mem_data_out;
  logic         mem_data_ready;
  logic         busy;
  logic         error;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_B = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] LINE_C = 128'h0F0F0F0F_10101010_20202020_30303030;
  localparam logic [127:0] LINE_D = 128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0;

  logic [11:0]  fair_addr [4];
  logic [127:0] fair_line [4];
  logic         fair_dc   [4];
  logic [127:0] last_ic_line;
  logic [127:0] last_dc_line;

  memory_arbiter #(
    .ADDRESS_SIZE(12),
    .CACHE_LINE_SIZE(128),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ic_req(ic_req),
    .ic_address(ic_address),
    .ic_data_out(ic_data_out),
    .ic_ready(ic_ready),
    .dc_req(dc_req),
    .dc_op(dc_op),
    .dc_address(dc_address),
    .dc_data_in(dc_data_in),
    .dc_data_out(dc_data_out),
    .dc_ready(dc_ready),
    .mem_enable(mem_enable),
    .mem_op(mem_op),
    .mem_address(mem_address),
    .mem_data_in(mem_data_in),
    .mem_op_done(mem_op_done),
    .mem_data_out(mem_data_out),
    .mem_data_ready(mem_data_ready),
    .busy(busy),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ic_req = 1'b0; ic_address = '0; dc_req = 1'b0; dc_op = 1'b0;
    dc_address = '0; dc_data_in = '0; mem_data_out = '0; mem_data_ready = 1'b0;

    fair_addr = '{12'h300, 12'h0C0, 12'h300, 12'h0C0};
    fair_dc   = '{1'b1, 1'b0, 1'b1, 1'b0};
    fair_line = '{LINE_A, LINE_B, LINE_C, LINE_D};

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_op", mem_op, 0);
    check("rst_mem_op_done", mem_op_done, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_ic_data_out", ic_data_out, 0);
    check("rst_dc_data_out", dc_data_out, 0);
    check("rst_ic_ready", ic_ready, 0);
    check("rst_dc_ready", dc_ready, 0);
    rst_n = 1'b1;

    // icache-only read, memory answers on the 4th BUSY edge
    ic_req = 1'b1; ic_address = 12'h040;
    tick();
    check("ic_rd_enable", mem_enable, 1);
    check("ic_rd_busy", busy, 1);
    check("ic_rd_addr", mem_address, 12'h040);
    check("ic_rd_op", mem_op, 0);
    tick(); tick(); tick();
    check("ic_rd_wait_ready", ic_ready, 0);
    check("ic_rd_wait_enable", mem_enable, 1);
    mem_data_ready = 1'b1; mem_data_out = LINE_A;
    tick();
    check("ic_rd_ready", ic_ready, 1);
    check("ic_rd_data", ic_data_out, LINE_A);
    check("ic_rd_dc_ready", dc_ready, 0);
    check("ic_rd_dc_data", dc_data_out, 0);
    check("ic_rd_done_enable", mem_enable, 0);
    check("ic_rd_op_done", mem_op_done, 1);
    ic_req = 1'b0; mem_data_ready = 1'b0;
    tick();
    check("ic_rd_pulse_once", ic_ready, 0);
    check("ic_rd_idle_busy", busy, 0);
    check("ic_rd_idle_op_done", mem_op_done, 0);

    // dcache write
    dc_req = 1'b1; dc_op = 1'b1; dc_address = 12'h100; dc_data_in = '1;
    tick();
    check("dc_wr_op", mem_op, 1);
    check("dc_wr_addr", mem_address, 12'h100);
    check("dc_wr_data", mem_data_in, {128{1'b1}});
    check("dc_wr_enable", mem_enable, 1);
    mem_data_ready = 1'b1; mem_data_out = LINE_B;
    tick();
    check("dc_wr_ready", dc_ready, 1);
    check("dc_wr_data_out", dc_data_out, 0);
    check("dc_wr_ic_ready", ic_ready, 0);
    check("dc_wr_ic_data", ic_data_out, LINE_A);
    dc_req = 1'b0; dc_op = 1'b0; mem_data_ready = 1'b0;
    tick();
    check("dc_wr_pulse_once", dc_ready, 0);
    check("dc_wr_idle_busy", busy, 0);

    // Simultaneous requests right after reset: dcache first, then icache
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ic_req = 1'b1; ic_address = 12'h080;
    dc_req = 1'b1; dc_op = 1'b0; dc_address = 12'h200;
    tick();
    check("tie_first_addr", mem_address, 12'h200);
    mem_data_ready = 1'b1; mem_data_out = LINE_C;
    tick();
    check("tie_first_dc_ready", dc_ready, 1);
    check("tie_first_ic_ready", ic_ready, 0);
    check("tie_first_dc_data", dc_data_out, LINE_C);
    dc_req = 1'b0; mem_data_ready = 1'b0;
    tick();
    check("tie_gap_idle", busy, 0);
    tick();
    check("tie_second_addr", mem_address, 12'h080);
    check("tie_second_op", mem_op, 0);
    mem_data_ready = 1'b1; mem_data_out = LINE_D;
    tick();
    check("tie_second_ic_ready", ic_ready, 1);
    check("tie_second_dc_ready", dc_ready, 0);
    check("tie_second_ic_data", ic_data_out, LINE_D);
    check("tie_second_dc_hold", dc_data_out, LINE_C);
    ic_req = 1'b0; mem_data_ready = 1'b0;
    tick();
    last_ic_line = LINE_D;
    last_dc_line = LINE_C;

    // Fairness with both requests held high
    ic_req = 1'b1; ic_address = 12'h0C0;
    dc_req = 1'b1; dc_op = 1'b0; dc_address = 12'h300;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fair%0d_addr", i), mem_address, fair_addr[i]);
      mem_data_ready = 1'b1; mem_data_out = fair_line[i];
      tick();
      if (fair_dc[i]) last_dc_line = fair_line[i];
      else last_ic_line = fair_line[i];
      check($sformatf("fair%0d_dc_ready", i), dc_ready, fair_dc[i]);
      check($sformatf("fair%0d_ic_ready", i), ic_ready, !fair_dc[i]);
      check($sformatf("fair%0d_dc_data", i), dc_data_out, last_dc_line);
      check($sformatf("fair%0d_ic_data", i), ic_data_out, last_ic_line);
      mem_data_ready = 1'b0;
      tick();
      check($sformatf("fair%0d_idle", i), busy, 0);
    end
    ic_req = 1'b0; dc_req = 1'b0;
    tick();

    // Timeout: memory never answers
    ic_req = 1'b1; ic_address = 12'h3F0;
    tick();
    check("to_busy", busy, 1);
    for (int i = 0; i < 14; i++) tick();
    check("to_before_error", error, 0);
    check("to_before_ready", ic_ready, 0);
    check("to_before_busy", busy, 1);
    tick();
    check("to_error", error, 1);
    check("to_ready", ic_ready, 1);
    check("to_data_kept", ic_data_out, last_ic_line);
    check("to_enable_off", mem_enable, 0);
    check("to_op_done", mem_op_done, 1);
    ic_req = 1'b0;
    tick();
    check("to_idle", busy, 0);
    check("to_op_done_clr", mem_op_done, 0);
    tick(); tick();
    check("to_error_sticky", error, 1);

    // Reset in the middle of a dcache read
    dc_req = 1'b1; dc_op = 1'b0; dc_address = 12'h123;
    tick();
    check("rb_enable", mem_enable, 1);
    tick();
    rst_n = 1'b0; mem_data_ready = 1'b1; mem_data_out = LINE_B;
    tick();
    check("rb_enable_off", mem_enable, 0);
    check("rb_no_ready", dc_ready, 0);
    check("rb_busy", busy, 0);
    check("rb_error_clr", error, 0);
    check("rb_dc_data", dc_data_out, 0);
    rst_n = 1'b1; mem_data_ready = 1'b0;
    ic_req = 1'b1; ic_address = 12'h456;
    tick();
    check("rb_tie_addr", mem_address, 12'h123);
    mem_data_ready = 1'b1; mem_data_out = LINE_A;
    tick();
    check("rb_tie_dc_ready", dc_ready, 1);
    check("rb_tie_dc_data", dc_data_out, LINE_A);
    dc_req = 1'b0; ic_req = 1'b0; mem_data_ready = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRESS_SIZE, 12, memory byte-address width; CACHE_LINE_SIZE, 128, line width in bits; TIMEOUT_CYCLES, 15, maximum BUSY cycles before abort.
REQ-002 Port list SHALL be (name direction width meaning):
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- ic_req  in  1  instruction-cache line-read request
- ic_address  in  ADDRESS_SIZE  icache line address
- ic_data_out  out  CACHE_LINE_SIZE  line returned to icache
- ic_ready  out  1  one-cycle icache completion pulse
- dc_req  in  1  data-cache request
- dc_op  in  1  0 = read, 1 = write
- dc_address  in  ADDRESS_SIZE  dcache line address
- dc_data_in  in  CACHE_LINE_SIZE  write line
- dc_data_out  out  CACHE_LINE_SIZE  line returned to dcache
- dc_ready  out  1  one-cycle dcache completion pulse
- mem_enable  out  1  memory enable
- mem_op  out  1  memory op, 0 = read, 1 = write
- mem_address  out  ADDRESS_SIZE  memory address
- mem_data_in  out  CACHE_LINE_SIZE  memory write data
- mem_op_done  out  1  end-of-operation acknowledge to memory
- mem_data_out  in  CACHE_LINE_SIZE  memory read data
- mem_data_ready  in  1  memory completion, high until mem_op_done seen
- busy  out  1  high whenever state is not IDLE
- error  out  1  sticky timeout flag
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-004 FSM states SHALL be IDLE, BUSY, DONE; all outputs SHALL be registered.
REQ-005 Requests SHALL be sampled only in IDLE; requesters hold req, op, address and data stable until their ready pulse, then drop req the next cycle.
REQ-006 IDLE with exactly one req high SHALL grant that requester; with both high, SHALL grant the requester not granted last (round-robin); last_grant SHALL reset to icache, so dcache wins the first tie.
REQ-007 On grant, the block SHALL latch address, op (icache always 0) and write data onto mem_address, mem_op and mem_data_in, set mem_enable = 1, clear the timeout counter, and enter BUSY on the same edge.
REQ-008 In BUSY, mem_address, mem_op and mem_data_in SHALL stay constant and the timeout counter SHALL increment by 1 per cycle.
REQ-009 BUSY with mem_data_ready = 1 SHALL, on one edge:
- for reads, copy mem_data_out into the granted requester's data_out;
- pulse the granted ready high for exactly one cycle;
- set mem_enable = 0 and mem_op_done = 1;
- update last_grant;
- enter DONE.
REQ-010 Writes SHALL leave dc_data_out unchanged; dc_ready SHALL still pulse.
REQ-011 BUSY with the counter equal to TIMEOUT_CYCLES-1 and mem_data_ready = 0 SHALL set error = 1, pulse the granted ready with data_out unchanged, drop mem_enable, assert mem_op_done and enter DONE.
REQ-012 DONE SHALL hold mem_op_done = 1 and SHALL return to IDLE, clearing mem_op_done, on the first edge where mem_data_ready = 0; minimum DONE residency is one cycle.
REQ-013 The non-granted requester's ready and data_out SHALL never change during another requester's transaction.
REQ-014 A req rising during BUSY or DONE SHALL be served in the next IDLE; no request SHALL be dropped.
REQ-015 Best-case latency, from req sampled in IDLE to ready high, SHALL be (memory response cycles + 1); back-to-back transactions SHALL have at least one IDLE cycle between them.
REQ-016 error SHALL clear only on reset.

Reset
REQ-017 With rst_n = 0 at a rising edge, the block SHALL set:
- state = IDLE, last_grant = icache, timeout counter = 0;
- mem_enable = mem_op = mem_op_done = 0;
- mem_address = 0, mem_data_in = 0;
- ic_data_out = dc_data_out = 0, ic_ready = dc_ready = 0;
- busy = 0, error = 0.
REQ-018 Reset asserted mid-BUSY or mid-DONE SHALL abort the transaction with no ready pulse; the first post-reset IDLE SHALL re-arbitrate from the reset state.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- icache-only read: ic_req=1, ic_address=0x040, memory returns 0x00112233_44556677_8899AABB_CCDDEEFF after 4 cycles -> ic_ready pulses once, ic_data_out equals that line, mem_op=0.
- dcache write: dc_op=1, dc_address=0x100, dc_data_in=0xFF..FF -> mem_op=1, mem_address=0x100, mem_data_in=0xFF..FF; dc_ready pulses once; dc_data_out stays 0.
- simultaneous requests after reset: dcache granted first; icache granted in the next IDLE; two ready pulses in the order dc, ic.
- contention fairness: ic_req and dc_req both held high for 4 transactions -> grants alternate dc, ic, dc, ic.
- timeout: mem_data_ready held 0 -> error=1 after 15 BUSY cycles, ready pulses, FSM returns to IDLE; error stays 1.
- reset mid-BUSY: rst_n=0 for one cycle during a dcache read -> mem_enable=0, no dc_ready pulse, busy=0; next tie grants dcache.
